// File: rtl/regfile_pkg.sv
// Shared defaults and scalar types for the multi-port register file.
`default_nettype none

package regfile_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;
  localparam int RF_NUM_WR = 2;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;
endpackage

`default_nettype wire

// File: rtl/regfile_mp_if.sv
// ----------------------------------------------------------------------------
// regfile_mp_if : read / writeback / issue bundle of the multi-port regfile
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = RF_NUM_RD,
  parameter int NUM_WR = RF_NUM_WR
);
  logic [NUM_RD-1:0][ADDR_W-1:0] i_rs_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] o_rs_data;
  logic [NUM_RD-1:0]             o_rs_busy;
  logic [NUM_WR-1:0][ADDR_W-1:0] i_rd_addr;
  logic [NUM_WR-1:0][DATA_W-1:0] i_rd_data;
  logic [NUM_WR-1:0]             i_rd_wren;
  logic [ADDR_W-1:0]             i_iss_addr;
  logic                          i_iss_valid;
  logic                          i_flush;

  modport master (
    output i_rs_addr, i_rd_addr, i_rd_data, i_rd_wren,
           i_iss_addr, i_iss_valid, i_flush,
    input  o_rs_data, o_rs_busy
  );

  modport slave (
    input  i_rs_addr, i_rd_addr, i_rd_data, i_rd_wren,
           i_iss_addr, i_iss_valid, i_flush,
    output o_rs_data, o_rs_busy
  );
endinterface

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard : per-register busy bits with issue/writeback/flush
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = RF_NUM_RD,
  parameter int NUM_WR = RF_NUM_WR
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] i_rd_addr,
  input  logic [NUM_WR-1:0]             i_rd_wren,
  input  logic [ADDR_W-1:0]             i_iss_addr,
  input  logic                          i_iss_valid,
  input  logic                          i_flush,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] i_rs_addr,
  output logic [NUM_RD-1:0]             o_rs_busy
);
  localparam int c_DEPTH = 2**ADDR_W;

  logic [c_DEPTH-1:0] r_busy;
  logic [c_DEPTH-1:0] w_clr;
  logic [c_DEPTH-1:0] w_busy_nxt;

  // Priority, lowest to highest: writeback clear, issue set, flush.
  always_comb begin
    w_clr = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (i_rd_wren[w]) w_clr[i_rd_addr[w]] = 1'b1;
    end
    w_busy_nxt = r_busy & ~w_clr;
    if (i_iss_valid) w_busy_nxt[i_iss_addr] = 1'b1;
    if (i_flush) w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_busy <= '0;
    else            r_busy <= w_busy_nxt;
  end

  // A same-cycle writeback hides the busy bit, matching the data bypass.
  always_comb begin
    o_rs_busy = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      o_rs_busy[r] = r_busy[i_rs_addr[r]] & ~w_clr[i_rs_addr[r]];
    end
  end
endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp : parametrised multi-port register file with write-through bypass
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = RF_NUM_RD,
  parameter int NUM_WR = RF_NUM_WR
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  regfile_mp_if.slave bus
);
  localparam int c_DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]             r_mem [c_DEPTH];
  logic [NUM_RD-1:0][DATA_W-1:0] w_rs_data;
  logic [NUM_RD-1:0]             w_rs_busy;

  // Later ports are assigned last, so the highest index wins a conflict.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.i_rd_wren[w] && (bus.i_rd_addr[w] != '0)) begin
          r_mem[bus.i_rd_addr[w]] <= bus.i_rd_data[w];
        end
      end
    end
  end

  always_comb begin
    w_rs_data = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      w_rs_data[r] = r_mem[bus.i_rs_addr[r]];
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.i_rd_wren[w] && (bus.i_rd_addr[w] == bus.i_rs_addr[r])) begin
          w_rs_data[r] = bus.i_rd_data[w];
        end
      end
      if (bus.i_rs_addr[r] == '0) w_rs_data[r] = '0;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_rd_addr   (bus.i_rd_addr),
    .i_rd_wren   (bus.i_rd_wren),
    .i_iss_addr  (bus.i_iss_addr),
    .i_iss_valid (bus.i_iss_valid),
    .i_flush     (bus.i_flush),
    .i_rs_addr   (bus.i_rs_addr),
    .o_rs_busy   (w_rs_busy)
  );

  assign bus.o_rs_data = w_rs_data;
  assign bus.o_rs_busy = w_rs_busy;
endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp : directed + random checks of regfile_mp against an array model
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int c_DEPTH = 2**RF_ADDR_W;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic [31:0] m_mem  [c_DEPTH];
  logic        m_busy [c_DEPTH];

  regfile_mp_if bus ();

  regfile_mp dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < c_DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    bus.i_rs_addr   = '0;
    bus.i_rd_addr   = '0;
    bus.i_rd_data   = '0;
    bus.i_rd_wren   = '0;
    bus.i_iss_addr  = '0;
    bus.i_iss_valid = 1'b0;
    bus.i_flush     = 1'b0;
  endtask

  // Expected read value: x0 is zero, else the highest-index writer to it, else storage.
  function automatic logic [31:0] exp_data(input int a);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = m_mem[a];
    for (int w = 0; w < RF_NUM_WR; w++)
      if (bus.i_rd_wren[w] && int'(bus.i_rd_addr[w]) == a) v = bus.i_rd_data[w];
    return v;
  endfunction

  function automatic logic exp_busy(input int a);
    for (int w = 0; w < RF_NUM_WR; w++)
      if (bus.i_rd_wren[w] && int'(bus.i_rd_addr[w]) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check_ports();
    for (int r = 0; r < RF_NUM_RD; r++) begin
      check($sformatf("data%0d x%0d", r, bus.i_rs_addr[r]),
            bus.o_rs_data[r], exp_data(int'(bus.i_rs_addr[r])));
      check($sformatf("busy%0d x%0d", r, bus.i_rs_addr[r]),
            {31'b0, bus.o_rs_busy[r]}, {31'b0, exp_busy(int'(bus.i_rs_addr[r]))});
    end
  endtask

  task automatic model_edge();
    for (int w = 0; w < RF_NUM_WR; w++) begin
      if (bus.i_rd_wren[w] && bus.i_rd_addr[w] != '0) begin
        m_mem[bus.i_rd_addr[w]]  = bus.i_rd_data[w];
        m_busy[bus.i_rd_addr[w]] = 1'b0;
      end
    end
    if (bus.i_iss_valid && bus.i_iss_addr != '0) m_busy[bus.i_iss_addr] = 1'b1;
    if (bus.i_flush)
      for (int i = 0; i < c_DEPTH; i++) m_busy[i] = 1'b0;
  endtask

  // Inputs are driven at the falling edge; outputs checked 1 time unit later.
  task automatic step();
    #1;
    check_ports();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle();
    model_reset();
    rst_n = 1'b0;
    bus.i_rs_addr[0] = 5'd5;
    bus.i_rs_addr[1] = 5'd9;
    #2;
    check("reset data0", bus.o_rs_data[0], 32'h0);
    check("reset busy", {30'b0, bus.o_rs_busy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Write x5, then async reset in the middle of the high phase.
    idle();
    bus.i_rd_wren[0] = 1'b1; bus.i_rd_addr[0] = 5'd5; bus.i_rd_data[0] = 32'hDEADBEEF;
    bus.i_iss_valid = 1'b1;  bus.i_iss_addr = 5'd9;
    step();
    idle();
    bus.i_rs_addr[0] = 5'd5; bus.i_rs_addr[1] = 5'd9;
    step();
    check("x5 before reset", bus.o_rs_data[0], 32'hDEADBEEF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("x5 after async reset", bus.o_rs_data[0], 32'h0);
    check("busy after async reset", {30'b0, bus.o_rs_busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // x0 protection.
    idle();
    bus.i_rd_wren[0] = 1'b1; bus.i_rd_addr[0] = 5'd0; bus.i_rd_data[0] = 32'h12345678;
    bus.i_iss_valid = 1'b1;  bus.i_iss_addr = 5'd0;
    #1;
    check("x0 same cycle", bus.o_rs_data[0], 32'h0);
    step();
    idle();
    #1;
    check("x0 next cycle", bus.o_rs_data[0], 32'h0);
    check("x0 busy", {31'b0, bus.o_rs_busy[0]}, 32'h0);
    step();

    // Bypass from port 1.
    bus.i_rd_wren[1] = 1'b1; bus.i_rd_addr[1] = 5'd7; bus.i_rd_data[1] = 32'hA5A5A5A5;
    bus.i_rs_addr[0] = 5'd7;
    #1;
    check("bypass x7", bus.o_rs_data[0], 32'hA5A5A5A5);
    step();
    idle();
    bus.i_rs_addr[0] = 5'd7;
    #1;
    check("stored x7", bus.o_rs_data[0], 32'hA5A5A5A5);
    step();

    // Write conflict on x3.
    bus.i_rd_wren = 2'b11;
    bus.i_rd_addr[0] = 5'd3; bus.i_rd_data[0] = 32'h1;
    bus.i_rd_addr[1] = 5'd3; bus.i_rd_data[1] = 32'h2;
    bus.i_rs_addr[1] = 5'd3;
    #1;
    check("conflict bypass x3", bus.o_rs_data[1], 32'h2);
    step();
    idle();
    bus.i_rs_addr[1] = 5'd3;
    #1;
    check("conflict stored x3", bus.o_rs_data[1], 32'h2);
    step();

    // Scoreboard on x9.
    bus.i_iss_valid = 1'b1; bus.i_iss_addr = 5'd9;
    step();
    idle();
    bus.i_rs_addr[0] = 5'd9;
    #1;
    check("x9 busy after issue", {31'b0, bus.o_rs_busy[0]}, 32'h1);
    bus.i_rd_wren[0] = 1'b1; bus.i_rd_addr[0] = 5'd9; bus.i_rd_data[0] = 32'h99;
    #1;
    check("x9 busy hidden by writeback", {31'b0, bus.o_rs_busy[0]}, 32'h0);
    step();
    idle();
    bus.i_rs_addr[0] = 5'd9;
    #1;
    check("x9 busy cleared", {31'b0, bus.o_rs_busy[0]}, 32'h0);
    bus.i_iss_valid = 1'b1; bus.i_iss_addr = 5'd9;
    bus.i_rd_wren[1] = 1'b1; bus.i_rd_addr[1] = 5'd9; bus.i_rd_data[1] = 32'h77;
    step();
    idle();
    bus.i_rs_addr[0] = 5'd9;
    #1;
    check("x9 set beats clear", {31'b0, bus.o_rs_busy[0]}, 32'h1);
    step();

    // Flush drops busy bits and a simultaneous issue.
    for (int k = 4; k <= 8; k += 2) begin
      idle();
      bus.i_iss_valid = 1'b1; bus.i_iss_addr = 5'(k);
      step();
    end
    idle();
    bus.i_rs_addr[0] = 5'd6; bus.i_rs_addr[1] = 5'd7;
    bus.i_flush = 1'b1; bus.i_iss_valid = 1'b1; bus.i_iss_addr = 5'd10;
    #1;
    check("x6 busy before flush", {31'b0, bus.o_rs_busy[0]}, 32'h1);
    step();
    for (int k = 4; k <= 10; k += 2) begin
      idle();
      bus.i_rs_addr[0] = 5'(k); bus.i_rs_addr[1] = 5'd7;
      #1;
      check($sformatf("x%0d busy after flush", k), {31'b0, bus.o_rs_busy[0]}, 32'h0);
      check("x7 kept across flush", bus.o_rs_data[1], 32'hA5A5A5A5);
      step();
    end

    // Random traffic on a narrow address range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < RF_NUM_RD; r++) bus.i_rs_addr[r] = 5'($urandom_range(0, 7));
      for (int w = 0; w < RF_NUM_WR; w++) begin
        bus.i_rd_addr[w] = 5'($urandom_range(0, 7));
        bus.i_rd_data[w] = $urandom;
        bus.i_rd_wren[w] = $urandom_range(0, 1) == 1;
      end
      bus.i_iss_addr  = 5'($urandom_range(0, 7));
      bus.i_iss_valid = $urandom_range(0, 1) == 1;
      bus.i_flush     = $urandom_range(0, 15) == 0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
